// File: rtl/captura_pkg.sv
// Shared types for the capture core: FSM state encoding, trigger mode codes
// and the edge/level trigger decision.
package captura_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } estado_t;

    localparam logic [1:0] TM_LEVEL = 2'b00;
    localparam logic [1:0] TM_RISE  = 2'b01;
    localparam logic [1:0] TM_FALL  = 2'b10;
    localparam logic [1:0] TM_FORCE = 2'b11;

    // Rising/falling refer to entering/leaving the masked match, not to raw bus edges.
    function automatic logic trig_hit(input logic [1:0] mode,
                                      input logic       match,
                                      input logic       prev_match);
        logic hit;
        hit = 1'b1;
        case (mode)
            TM_LEVEL: hit = match;
            TM_RISE:  hit = match && !prev_match;
            TM_FALL:  hit = !match && prev_match;
            default:  hit = 1'b1;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/captura_ram.sv
// Simple dual-port sample buffer: synchronous write, registered synchronous
// read whose output holds while no read is requested.
module captura_ram #(
    parameter int  DATA_W = 14,
    parameter int  DEPTH  = 1024,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array itself is never reset, so it maps onto block RAM; only
    // the read register is cleared, keeping rd_data at 0 after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/captura_disparo.sv
// Logic-analyser capture core: ring buffer with programmable pre-trigger
// depth, masked level/edge/force trigger, and windowed readout port.
module captura_disparo
    import captura_pkg::*;
#(
    parameter int  DATA_W    = 14,
    parameter int  TRIG_W    = 5,
    parameter int  DEPTH     = 1024,
    parameter int  PRE_DEPTH = 256,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic              smp_en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic [TRIG_W-1:0] trig_val_i,
    input  logic [1:0]        trig_mode_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic [2:0]        estado_o,
    output logic              armed_o,
    output logic              triggered_o,
    output logic              done_o
);

    localparam logic [AW-1:0] PRE_LEN   = AW'(PRE_DEPTH);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_DEPTH - 1);
    localparam logic [AW:0]   POST_LAST = (AW + 1)'(DEPTH - PRE_DEPTH - 1);

    estado_t           estado;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     trig_ptr;
    logic [AW-1:0]     pre_cnt;
    logic [AW:0]       post_cnt;
    logic              prev_match;

    logic              match;
    logic              hit;
    logic              arm_ok;
    logic              we;
    logic [AW-1:0]     win_start;
    logic [AW-1:0]     rd_addr_phys;

    // NOTE: every signal driven here gets a value before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        match        = ((trig_i ^ trig_val_i) & trig_mask_i) == '0;
        hit          = trig_hit(trig_mode_i, match, prev_match);
        arm_ok       = arm_i && (estado == IDLE || estado == DONE);
        we           = smp_en_i && !abort_i && !rst_i &&
                       (estado == PRE || estado == WAIT || estado == POST);
        win_start    = trig_ptr - PRE_LEN;
        rd_addr_phys = win_start + rd_addr_i;
    end

    // Abort outranks arm; arm is only honoured from IDLE or DONE.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            estado      <= IDLE;
            wr_ptr      <= '0;
            trig_ptr    <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            prev_match  <= 1'b0;
            armed_o     <= 1'b0;
            triggered_o <= 1'b0;
            done_o      <= 1'b0;
        end else if (abort_i) begin
            estado  <= IDLE;
            armed_o <= 1'b0;
            done_o  <= 1'b0;
        end else if (arm_ok) begin
            estado      <= (PRE_DEPTH == 0) ? WAIT : PRE;
            wr_ptr      <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            prev_match  <= 1'b0;
            armed_o     <= 1'b1;
            triggered_o <= 1'b0;
            done_o      <= 1'b0;
        end else if (smp_en_i) begin
            prev_match <= match;
            unique case (estado)
                PRE: begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    pre_cnt <= pre_cnt + 1'b1;
                    if (pre_cnt == PRE_LAST) begin
                        estado <= WAIT;
                    end
                end
                WAIT: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (hit) begin
                        trig_ptr    <= wr_ptr;
                        post_cnt    <= (AW + 1)'(1);
                        triggered_o <= 1'b1;
                        armed_o     <= 1'b0;
                        if (DEPTH - PRE_DEPTH == 1) begin
                            estado <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            estado <= POST;
                        end
                    end
                end
                POST: begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    post_cnt <= post_cnt + 1'b1;
                    // The sample written in this cycle completes the window.
                    if (post_cnt == POST_LAST) begin
                        estado <= DONE;
                        done_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_en_i && (estado == DONE);
        end
    end

    assign estado_o = estado;

    captura_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk_i),
        .rst   (rst_i),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (data_i),
        .re    (rd_en_i),
        .raddr (rd_addr_phys),
        .rdata (rd_data_o)
    );

endmodule
